// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer and its surroundings: memory data/handshake,
// decoder/ALU carry controls, halt request, and the registered decoder inputs.
interface fetch_sequencer_if;
    logic [7:0] mem_data;
    logic       mem_ready;
    logic       WC;
    logic       alu_carry;
    logic       halt_req;
    logic [7:0] inst;
    logic       cycle;
    logic       ncycle;
    logic       carry;
    logic       pc_inc;
    logic       halted;
    logic       bus_err;

    // Environment side: memory, decoder and ALU drive the sequencer.
    modport master (
        output mem_data, mem_ready, WC, alu_carry, halt_req,
        input  inst, cycle, ncycle, carry, pc_inc, halted, bus_err
    );

    // Sequencer side.
    modport slave (
        input  mem_data, mem_ready, WC, alu_carry, halt_req,
        output inst, cycle, ncycle, carry, pc_inc, halted, bus_err
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the instruction register, the cycle/ncycle phase flops
// and the carry flag; steps two-cycle instructions, stalls on mem_ready,
// honours halt requests at instruction boundaries and flags a bus error after
// a bounded memory wait.
module fetch_sequencer #(
    parameter logic [7:0]  RESET_INST = 8'h00,
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned WAIT_W     = 8
) (
    input  logic              clk,
    input  logic              nrst,
    fetch_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        C0   = 2'd0,
        C1   = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

    state_t            state, state_nxt;
    logic [7:0]        inst_q, inst_nxt;
    logic              cycle_q, ncycle_q;
    logic              carry_q, carry_nxt;
    logic              berr_q, berr_nxt;
    logic [WAIT_W-1:0] wait_q, wait_nxt;
    logic              boundary;
    logic              fetch;

    // Next-state decode: boundary/halt priority, advance, stall counting, halt exit.
    always_comb begin
        state_nxt = state;
        inst_nxt  = inst_q;
        carry_nxt = carry_q;
        berr_nxt  = berr_q;
        wait_nxt  = wait_q;
        fetch     = 1'b0;
        boundary  = ((state == C0) && !inst_q[7]) || (state == C1);

        case (state)
            C0, C1: begin
                if (boundary && bus.halt_req) begin
                    state_nxt = HALT;
                    wait_nxt  = '0;
                end else if (bus.mem_ready && !berr_q) begin
                    wait_nxt = '0;
                    if (boundary) begin
                        fetch     = 1'b1;
                        inst_nxt  = bus.mem_data;
                        state_nxt = C0;
                    end else begin
                        state_nxt = C1;
                    end
                    if (bus.WC) begin
                        carry_nxt = bus.alu_carry;
                    end
                end else begin
                    // The edge completing the WAIT_LIMIT-th stalled cycle raises the error.
                    wait_nxt = wait_q + 1'b1;
                    if (wait_q == WAIT_LAST) begin
                        berr_nxt  = 1'b1;
                        state_nxt = HALT;
                    end
                end
            end
            HALT: begin
                if (!bus.halt_req && !berr_q && bus.mem_ready) begin
                    fetch     = 1'b1;
                    inst_nxt  = bus.mem_data;
                    state_nxt = C0;
                    wait_nxt  = '0;
                end
            end
            default: begin
                state_nxt = C0;
            end
        endcase
    end

    // State, instruction register, phase flops, carry, error flag and wait counter.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= C0;
            inst_q   <= RESET_INST;
            cycle_q  <= 1'b0;
            ncycle_q <= 1'b1;
            carry_q  <= 1'b0;
            berr_q   <= 1'b0;
            wait_q   <= '0;
        end else begin
            state    <= state_nxt;
            inst_q   <= inst_nxt;
            cycle_q  <= (state_nxt == C1);
            ncycle_q <= (state_nxt != C1);
            carry_q  <= carry_nxt;
            berr_q   <= berr_nxt;
            wait_q   <= wait_nxt;
        end
    end

    assign bus.inst    = inst_q;
    assign bus.cycle   = cycle_q;
    assign bus.ncycle  = ncycle_q;
    assign bus.carry   = carry_q;
    assign bus.pc_inc  = fetch & nrst;
    assign bus.halted  = (state == HALT);
    assign bus.bus_err = berr_q;

endmodule
